expr_eval: RTL and testbench
============================

# expr_eval

Downstream companion to the ASCII expression recognizer. It consumes the same one-character-per-clock ASCII stream and computes the integer value of the longest valid prefix. The grammar:
- operands are unsigned 1–2 digit decimals with no leading zero (`0`, `7`, `42`; `05` is illegal);
- operators are `+` and `*`, with `*` binding tighter;
- one level of parentheses, containing only numbers and operators.

It publishes the value, a done flag that matches the recognizer's acceptance, a sticky overflow flag and a sticky syntax-error flag.

## Interface
- W, 16, result/accumulator width in bits; legal range 8..32.
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in  in  8  ASCII character, one consumed per rising clk edge.
- value  out  W  evaluated value of the stream so far (mod 2^W), registered.
- done  out  1  1 when the consumed stream is a complete valid expression, registered.
- ovf  out  1  sticky: some intermediate result exceeded 2^W−1.
- bad  out  1  sticky: the stream has become syntactically invalid.

## Operation
- Character classes:
  - digit 0x30–0x39;
  - zero 0x30;
  - op 0x2A/0x2B;
  - lp 0x28;
  - rp 0x29;
  - all other codes are illegal.
- FSM states and transitions. Any character not listed for a state → DEAD.
  - START: zero→Z, nonzero digit→N1, lp→LP.
  - Z: op→OP.
  - N1: digit→N2, op→OP.
  - N2: op→OP.
  - OP: same as START.
  - LP: zero→PZ, nonzero digit→PN1.
  - PZ: op→POP, rp→RP.
  - PN1: digit→PN2, op→POP, rp→RP.
  - PN2: op→POP, rp→RP.
  - POP: same as LP.
  - RP: op→OP.
  - DEAD: absorbing until clr.
- done=1 exactly in Z, N1, N2, RP; 0 elsewhere.
- bad is set on entry to DEAD and stays 1 until clr.
- Top-level registers (W bits):
  - S: sum of completed terms, reset 0.
  - P: product of completed factors of the current term, reset 1.
  - C: current factor, reset 0.
- Inner registers IS/IP/IC have the same roles inside the parentheses and the same reset values.
- Updates on the accepted character:
  - first digit d: C=d. Second digit d: C=C*10+d.
  - `*`: P=P*C.
  - `+`: S=S+P*C, then P=1.
  - lp: IS=0, IP=1, IC=0.
  - digits and ops inside parentheses act identically on IS/IP/IC.
  - rp: C=IS+IP*IC.
- value is loaded with S'+P'*C' (the post-update values) on every edge that lands in a done=1 state. Otherwise value holds.
- Width rule:
  - every product and sum is formed at 2W bits and truncated to W;
  - if any discarded bit is 1, ovf is set;
  - arithmetic continues on the truncated value.
- DEAD: all arithmetic registers, value, done=0, ovf and bad hold.

## Timing
- Reset values, applied asynchronously while clr=1:
  - state=START;
  - S=0, P=1, C=0; IS=0, IP=1, IC=0;
  - value=0, done=0, ovf=0, bad=0.
- Latency: the character sampled at edge k is reflected in state, value, done, ovf and bad immediately after edge k. There are no extra pipeline stages.
- done tracks the recognizer's out cycle-for-cycle on the same stream.
- No handshake; every edge with clr=0 consumes `in`.
- clr asserted mid-expression discards all partial results. The first edge after clr deasserts consumes a fresh first character.
- Nested `(` inside parentheses → DEAD. `)` at top level → DEAD. Empty `()` → DEAD.
- An operand after `)` with no operator (e.g. `(1)2`) → DEAD.

## Test plan
- Operator precedence.
  - Stimulus: `1`,`2`,`+`,`3`,`*`,`4`.
  - Response: done after each char = 1,1,0,1,0,1; value = 1,12,12,15,15,24; ovf=0, bad=0.
- Parentheses.
  - Stimulus: `(`,`1`,`+`,`2`,`)`,`*`,`3`.
  - Response: done=0 until `)`; value=3 after `)`; value=9 and done=1 after `3`.
- Leading zero.
  - Stimulus: `0`,`5`.
  - Response: after `0`, done=1 and value=0. After `5`, done=0, bad=1, value stays 0; further `+`,`1` leave everything unchanged.
- Overflow with W=8.
  - Stimulus: `9`,`9`,`*`,`9`,`9`.
  - Response: value=73 (9801 mod 256), ovf=1, done=1.
  - A following `+`,`1` gives value=74 with ovf still 1.
- Reset mid-stream.
  - Stimulus: `5`,`+`, then clr pulse, then `7`.
  - Response: all outputs at reset values during clr; afterwards value=7, done=1, bad=0.
- Illegal structure.
  - Stimulus: `(`,`(`, then `)` at top level on a fresh stream, then `(`,`)`.
  - Response: each case enters DEAD with bad=1 and done=0; value holds its last loaded value (0).

Source files
------------

// File: rtl/expr_eval.sv
// Evaluates the longest valid prefix of an ASCII arithmetic stream (+, *, one level of parens),
// one character per clock, with sticky overflow and syntax-error flags.
module expr_eval #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   output logic [W-1:0] value,
   output logic         done,
   output logic         ovf,
   output logic         bad
);

   typedef enum logic [3:0] {
      START, Z, N1, N2, OP, LP, PZ, PN1, PN2, POP, RP, DEAD
   } state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] TEN = {{(W-4){1'b0}}, 4'd10};

   // Results carry the truncated value in [W-1:0] and a "discarded bits nonzero" flag in [W].
   function automatic logic [W:0] mul_t(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] f;
      f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return {|f[2*W-1:W], f[W-1:0]};
   endfunction

   function automatic logic [W:0] add_t(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] f;
      f = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      return {|f[2*W-1:W], f[W-1:0]};
   endfunction

   state_t       state, n_state;
   logic [W-1:0] sum, prod, cur, isum, iprod, icur;
   logic [W-1:0] n_sum, n_prod, n_cur, n_isum, n_iprod, n_icur;
   logic         hit, n_done;

   logic is_dig, is_zero, is_nz, is_op, is_mul, is_lp, is_rp;
   assign is_dig  = (in >= 8'h30) && (in <= 8'h39);
   assign is_zero = (in == 8'h30);
   assign is_nz   = is_dig && !is_zero;
   assign is_mul  = (in == 8'h2A);
   assign is_op   = is_mul || (in == 8'h2B);
   assign is_lp   = (in == 8'h28);
   assign is_rp   = (in == 8'h29);

   logic [W-1:0] dig;
   assign dig = {{(W-4){1'b0}}, in[3:0]};

   // Candidate arithmetic for each kind of accepted character.
   logic [W:0] c10, c2, pc, spc, ic10, ic2, ipc, ispc, vpc, vsum;
   assign c10  = mul_t(cur, TEN);
   assign c2   = add_t(c10[W-1:0], dig);
   assign pc   = mul_t(prod, cur);
   assign spc  = add_t(sum, pc[W-1:0]);
   assign ic10 = mul_t(icur, TEN);
   assign ic2  = add_t(ic10[W-1:0], dig);
   assign ipc  = mul_t(iprod, icur);
   assign ispc = add_t(isum, ipc[W-1:0]);

   always_comb begin
      n_state = DEAD;
      case (state)
         START, OP: if (is_zero) n_state = Z;  else if (is_nz) n_state = N1;  else if (is_lp) n_state = LP;
         Z:         if (is_op)   n_state = OP;
         N1:        if (is_dig)  n_state = N2; else if (is_op) n_state = OP;
         N2:        if (is_op)   n_state = OP;
         LP, POP:   if (is_zero) n_state = PZ; else if (is_nz) n_state = PN1;
         PZ, PN2:   if (is_op)   n_state = POP; else if (is_rp) n_state = RP;
         PN1:       if (is_dig)  n_state = PN2; else if (is_op) n_state = POP; else if (is_rp) n_state = RP;
         RP:        if (is_op)   n_state = OP;
         default:   n_state = DEAD;
      endcase
   end

   // Arithmetic is keyed on the destination state, so DEAD naturally leaves everything alone.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      n_sum   = sum;
      n_prod  = prod;
      n_cur   = cur;
      n_isum  = isum;
      n_iprod = iprod;
      n_icur  = icur;
      hit     = 1'b0;
      case (n_state)
         Z, N1:   n_cur = dig;
         N2:      begin n_cur = c2[W-1:0]; hit = c10[W] | c2[W]; end
         OP:      if (is_mul) begin
                     n_prod = pc[W-1:0];
                     hit    = pc[W];
                  end else begin
                     n_sum  = spc[W-1:0];
                     n_prod = ONE;
                     hit    = pc[W] | spc[W];
                  end
         LP:      begin n_isum = '0; n_iprod = ONE; n_icur = '0; end
         PZ, PN1: n_icur = dig;
         PN2:     begin n_icur = ic2[W-1:0]; hit = ic10[W] | ic2[W]; end
         POP:     if (is_mul) begin
                     n_iprod = ipc[W-1:0];
                     hit     = ipc[W];
                  end else begin
                     n_isum  = ispc[W-1:0];
                     n_iprod = ONE;
                     hit     = ipc[W] | ispc[W];
                  end
         RP:      begin n_cur = ispc[W-1:0]; hit = ipc[W] | ispc[W]; end
         default: ;
      endcase
   end

   assign n_done = (n_state == Z) || (n_state == N1) || (n_state == N2) || (n_state == RP);
   assign vpc    = mul_t(n_prod, n_cur);
   assign vsum   = add_t(n_sum, vpc[W-1:0]);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= START;
         sum   <= '0;
         prod  <= ONE;
         cur   <= '0;
         isum  <= '0;
         iprod <= ONE;
         icur  <= '0;
         value <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         bad   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= n_state;
         sum   <= n_sum;
         prod  <= n_prod;
         cur   <= n_cur;
         isum  <= n_isum;
         iprod <= n_iprod;
         icur  <= n_icur;
         done  <= n_done;
         if (n_done) value <= vsum[W-1:0];
         ovf   <= ovf | hit | (n_done & (vpc[W] | vsum[W]));
         bad   <= bad | (n_state == DEAD);
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval at W=8; expected values are hand-computed.
module tb_expr_eval;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic [7:0]   in;
   logic [W-1:0] value;
   logic         done;
   logic         ovf;
   logic         bad;

   int passed = 0;
   int total  = 0;

   expr_eval #(.W(W)) dut (
      .clk(clk), .clr(clr), .in(in),
      .value(value), .done(done), .ovf(ovf), .bad(bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic expect_out(input string tag, input int v, input bit d, input bit o, input bit b);
      check({tag, ".value"}, 32'(value), 32'(v));
      check({tag, ".done"},  32'(done),  32'(d));
      check({tag, ".ovf"},   32'(ovf),   32'(o));
      check({tag, ".bad"},   32'(bad),   32'(b));
   endtask

   // Drive a character, let one rising edge consume it, sample shortly after.
   task automatic send(input byte ch);
      in = ch;
      @(posedge clk);
      #1;
   endtask

   // Called just after a sample point; clr is released well before the next edge.
   task automatic pulse_clr(input string tag);
      clr = 1'b1;
      #2;
      expect_out(tag, 0, 0, 0, 0);
      clr = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      in  = 8'h00;
      #12;
      expect_out("reset", 0, 0, 0, 0);
      clr = 1'b0;

      // Precedence: 12+3*4
      send("1"); expect_out("prec1", 1, 1, 0, 0);
      send("2"); expect_out("prec2", 12, 1, 0, 0);
      send("+"); expect_out("prec3", 12, 0, 0, 0);
      send("3"); expect_out("prec4", 15, 1, 0, 0);
      send("*"); expect_out("prec5", 15, 0, 0, 0);
      send("4"); expect_out("prec6", 24, 1, 0, 0);

      // Parentheses: (1+2)*3
      pulse_clr("clr_a");
      send("("); expect_out("par1", 0, 0, 0, 0);
      send("1"); expect_out("par2", 0, 0, 0, 0);
      send("+"); expect_out("par3", 0, 0, 0, 0);
      send("2"); expect_out("par4", 0, 0, 0, 0);
      send(")"); expect_out("par5", 3, 1, 0, 0);
      send("*"); expect_out("par6", 3, 0, 0, 0);
      send("3"); expect_out("par7", 9, 1, 0, 0);

      // Leading zero kills the stream; DEAD absorbs further input.
      pulse_clr("clr_b");
      send("0"); expect_out("lz1", 0, 1, 0, 0);
      send("5"); expect_out("lz2", 0, 0, 0, 1);
      send("+"); expect_out("lz3", 0, 0, 0, 1);
      send("1"); expect_out("lz4", 0, 0, 0, 1);

      // Overflow at W=8: 99*99 = 9801 -> 73; 99*9 = 891 -> 123 on the way.
      pulse_clr("clr_c");
      send("9"); expect_out("ov1", 9, 1, 0, 0);
      send("9"); expect_out("ov2", 99, 1, 0, 0);
      send("*"); expect_out("ov3", 99, 0, 0, 0);
      send("9"); expect_out("ov4", 123, 1, 1, 0);
      send("9"); expect_out("ov5", 73, 1, 1, 0);
      send("+"); expect_out("ov6", 73, 0, 1, 0);
      send("1"); expect_out("ov7", 74, 1, 1, 0);

      // Reset mid-stream discards partial results.
      pulse_clr("clr_d");
      send("5"); expect_out("rst1", 5, 1, 0, 0);
      send("+"); expect_out("rst2", 5, 0, 0, 0);
      pulse_clr("clr_mid");
      send("7"); expect_out("rst3", 7, 1, 0, 0);

      // Illegal structures.
      pulse_clr("clr_e");
      send("("); expect_out("nest1", 0, 0, 0, 0);
      send("("); expect_out("nest2", 0, 0, 0, 1);
      pulse_clr("clr_f");
      send(")"); expect_out("toprp", 0, 0, 0, 1);
      pulse_clr("clr_g");
      send("("); expect_out("empty1", 0, 0, 0, 0);
      send(")"); expect_out("empty2", 0, 0, 0, 1);

      // Operand directly after ')' holds the last loaded value.
      pulse_clr("clr_h");
      send("("); send("1");
      send(")"); expect_out("rpd1", 1, 1, 0, 0);
      send("2"); expect_out("rpd2", 1, 0, 0, 1);

      // Illegal character, then two-digit operand inside parens.
      pulse_clr("clr_i");
      send("3"); send("a"); expect_out("ill", 3, 0, 0, 1);
      pulse_clr("clr_j");
      send("("); send("1"); send("2"); send("*"); send("2");
      send(")"); expect_out("p2d", 24, 1, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
